// File: rtl/pe_config_scheduler.sv
// Run sequencer for a PE chain: streams ROM config words into the chain, then waits for every PE to finish.
// Optional watchdog on the RUN phase is enabled by defining PE_SCHED_TIMEOUT_EN.
module pe_config_scheduler #(
    parameter int NUM_PE         = 2,
    parameter int WORDS_PER_PE   = 2,
    parameter int CONF_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  rom_rd_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [CONF_WIDTH-1:0] rom_data,
    output logic                  config_input_valid,
    output logic [CONF_WIDTH-1:0] config_input,
    output logic                  config_input_done,
    input  logic [NUM_PE-1:0]     pe_done,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  cycle_count
`ifdef PE_SCHED_TIMEOUT_EN
    ,
    output logic                  timeout
`endif
);

    localparam int TOTAL = NUM_PE * WORDS_PER_PE;
    localparam int WCW   = $clog2(TOTAL + 1);

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, FINISH} state_t;

    state_t                state_q, state_d;
    logic [WCW-1:0]        word_cnt_q, word_cnt_d;
    logic                  flush_q, flush_d;
    logic [NUM_PE-1:0]     sticky_q, sticky_d;
    logic                  rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  busy_d, done_d, cfg_done_d;
    logic [CNT_WIDTH-1:0]  count_d;
    logic                  rd_q;
    logic                  all_done;
`ifdef PE_SCHED_TIMEOUT_EN
    logic                  timeout_d;
`endif

    assign all_done = &(sticky_q | pe_done);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= IDLE;
            word_cnt_q        <= '0;
            flush_q           <= 1'b0;
            sticky_q          <= '0;
            rom_rd_en         <= 1'b0;
            rom_addr          <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            config_input_done <= 1'b0;
            cycle_count       <= '0;
`ifdef PE_SCHED_TIMEOUT_EN
            timeout           <= 1'b0;
`endif
        end else begin
            state_q           <= state_d;
            word_cnt_q        <= word_cnt_d;
            flush_q           <= flush_d;
            sticky_q          <= sticky_d;
            rom_rd_en         <= rd_en_d;
            rom_addr          <= addr_d;
            busy              <= busy_d;
            done              <= done_d;
            config_input_done <= cfg_done_d;
            cycle_count       <= count_d;
`ifdef PE_SCHED_TIMEOUT_EN
            timeout           <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        flush_d    = flush_q;
        sticky_d   = sticky_q;
        rd_en_d    = 1'b0;
        addr_d     = rom_addr;
        busy_d     = busy;
        done_d     = 1'b0;
        cfg_done_d = config_input_done;
        count_d    = cycle_count;
`ifdef PE_SCHED_TIMEOUT_EN
        timeout_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                busy_d     = 1'b0;
                cfg_done_d = 1'b0;
                if (start) begin
                    state_d    = LOAD;
                    busy_d     = 1'b1;
                    addr_d     = '0;
                    word_cnt_d = '0;
                    count_d    = '0;
                    sticky_d   = '0;
                end
            end
            LOAD: begin
                if (word_cnt_q == WCW'(TOTAL)) begin
                    state_d = FLUSH;
                    flush_d = 1'b0;
                end else begin
                    rd_en_d    = 1'b1;
                    addr_d     = ADDR_WIDTH'(word_cnt_q);
                    word_cnt_d = word_cnt_q + WCW'(1);
                end
            end
            // Two cycles let the last ROM word drain through the read/register pipeline.
            FLUSH: begin
                if (flush_q) begin
                    state_d    = RUN;
                    cfg_done_d = 1'b1;
                end else begin
                    flush_d = 1'b1;
                end
            end
            RUN: begin
                if (cycle_count != '1) begin
                    count_d = cycle_count + CNT_WIDTH'(1);
                end
                sticky_d = sticky_q | pe_done;
                if (all_done) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end
`ifdef PE_SCHED_TIMEOUT_EN
                else if (count_d == CNT_WIDTH'(TIMEOUT_CYCLES)) begin
                    state_d   = FINISH;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
`endif
            end
            FINISH: begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                cfg_done_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ROM answers one cycle after the strobe; the word is registered one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q               <= 1'b0;
            config_input_valid <= 1'b0;
            config_input       <= '0;
        end else begin
            rd_q               <= rom_rd_en;
            config_input_valid <= rd_q;
            if (rd_q) begin
                config_input <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_pe_config_scheduler.sv
// Directed bench for pe_config_scheduler: per-cycle expectations derived from the cycle index of each run.
module tb_pe_config_scheduler;

    logic        tb_clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rom_rd_en;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic        config_input_valid;
    logic [31:0] config_input;
    logic        config_input_done;
    logic [1:0]  pe_done;
    logic        busy;
    logic        done;
    logic [31:0] cycle_count;
`ifdef PE_SCHED_TIMEOUT_EN
    logic        timeout;
`endif

    int testsRun    = 0;
    int testsFailed = 0;
    int validCount;
    int doneCount;

    logic [31:0] rom [4];

    pe_config_scheduler #(
        .NUM_PE(2), .WORDS_PER_PE(2), .CONF_WIDTH(32), .ADDR_WIDTH(8),
        .CNT_WIDTH(32), .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(tb_clk),
        .rst(rst),
        .start(start),
        .rom_rd_en(rom_rd_en),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .config_input_valid(config_input_valid),
        .config_input(config_input),
        .config_input_done(config_input_done),
        .pe_done(pe_done),
        .busy(busy),
        .done(done),
        .cycle_count(cycle_count)
`ifdef PE_SCHED_TIMEOUT_EN
        ,
        .timeout(timeout)
`endif
    );

    always #5 tb_clk = ~tb_clk;

    always @(posedge tb_clk) begin
        if (rom_rd_en) rom_data <= rom[rom_addr[1:0]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench #1 after the edge that accepted start (cycle 0).
    task automatic applyStimulus();
        @(negedge tb_clk);
        start = 1'b1;
        @(posedge tb_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic nextCycle(input int n);
        if (n > 0) begin
            @(posedge tb_clk);
            #1;
        end
    endtask

    task automatic checkCycle(input int n, input int doneCycle);
        logic expRd, expValid;
        expRd    = (n >= 1 && n <= 4);
        expValid = (n >= 3 && n <= 6);
        checkOutput($sformatf("busy@%0d", n), 32'(busy), 32'(n <= doneCycle));
        checkOutput($sformatf("rd_en@%0d", n), 32'(rom_rd_en), 32'(expRd));
        checkOutput($sformatf("valid@%0d", n), 32'(config_input_valid), 32'(expValid));
        checkOutput($sformatf("cfg_done@%0d", n), 32'(config_input_done), 32'(n >= 7 && n <= doneCycle));
        checkOutput($sformatf("done@%0d", n), 32'(done), 32'(n == doneCycle));
        if (expRd) checkOutput($sformatf("addr@%0d", n), 32'(rom_addr), 32'(n - 1));
        if (expValid) checkOutput($sformatf("cfg@%0d", n), config_input, rom[n - 3]);
    endtask

    initial begin
        rom[0] = 32'd1; rom[1] = 32'd5; rom[2] = 32'd7; rom[3] = 32'd9;
        rst = 1'b0; start = 1'b0; pe_done = 2'b00;
        #12;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_rd_en", 32'(rom_rd_en), 32'd0);
        checkOutput("reset_valid", 32'(config_input_valid), 32'd0);
        checkOutput("reset_count", cycle_count, 32'd0);
        @(negedge tb_clk);
        rst = 1'b1;

        // Pulsed and level pe_done; run ends one edge after both are seen.
        $display("[TB] scenario: basic run");
        applyStimulus();
        for (int n = 0; n <= 18; n++) begin
            nextCycle(n);
            checkCycle(n, 16);
            if (n == 16 || n == 18) checkOutput($sformatf("count@%0d", n), cycle_count, 32'd9);
            pe_done = (n == 10) ? 2'b01 : ((n >= 15) ? 2'b10 : 2'b00);
        end
        pe_done = 2'b00;

        $display("[TB] scenario: pe_done held before RUN");
        pe_done = 2'b11;
        applyStimulus();
        for (int n = 0; n <= 10; n++) begin
            nextCycle(n);
            checkCycle(n, 8);
            if (n == 8) checkOutput("count_early_done", cycle_count, 32'd1);
        end
        pe_done = 2'b00;

        $display("[TB] scenario: start while busy");
        validCount = 0;
        doneCount  = 0;
        applyStimulus();
        for (int n = 0; n <= 20; n++) begin
            nextCycle(n);
            checkCycle(n, 13);
            validCount += int'(config_input_valid);
            doneCount  += int'(done);
            start   = (n == 4);
            pe_done = (n >= 12) ? 2'b11 : 2'b00;
        end
        start   = 1'b0;
        pe_done = 2'b00;
        checkOutput("valid_words", 32'(validCount), 32'd4);
        checkOutput("done_pulses", 32'(doneCount), 32'd1);

        $display("[TB] scenario: async reset mid-load");
        applyStimulus();
        for (int n = 1; n <= 3; n++) nextCycle(n);
        checkOutput("pre_reset_rd_en", 32'(rom_rd_en), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_rd_en", 32'(rom_rd_en), 32'd0);
        checkOutput("arst_addr", 32'(rom_addr), 32'd0);
        checkOutput("arst_valid", 32'(config_input_valid), 32'd0);
        checkOutput("arst_cfg", config_input, 32'd0);
        checkOutput("arst_cfg_done", 32'(config_input_done), 32'd0);
        checkOutput("arst_done", 32'(done), 32'd0);
        checkOutput("arst_count", cycle_count, 32'd0);
        @(negedge tb_clk);
        rst = 1'b1;
        applyStimulus();
        for (int n = 0; n <= 10; n++) begin
            nextCycle(n);
            checkCycle(n, 8);
            pe_done = (n >= 7) ? 2'b11 : 2'b00;
        end
        pe_done = 2'b00;

        $display("[TB] scenario: PEs never finish");
        applyStimulus();
        for (int n = 0; n <= 40; n++) begin
            nextCycle(n);
`ifdef PE_SCHED_TIMEOUT_EN
            checkCycle(n, 27);
            checkOutput($sformatf("timeout@%0d", n), 32'(timeout), 32'(n == 27));
            if (n == 27) checkOutput("count_timeout", cycle_count, 32'd20);
`else
            checkCycle(n, 1000);
            if (n == 40) checkOutput("count_no_timeout", cycle_count, 32'd33);
`endif
        end
        rst = 1'b0;
        #3;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
